// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment scanner:
// the hex segment table, the blank pattern and the slot index width.
package display_pkg;

  localparam int IDX_W = 3;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high segments, bit 0 = a ... bit 6 = g; entry i is the glyph for nibble i.
  localparam logic [15:0][6:0] HEX7_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
    7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
    7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
    7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
  };

  function automatic logic [6:0] hex7(input logic [3:0] nibble);
    return HEX7_LUT[nibble];
  endfunction

endpackage

// File: rtl/decod_hex7.sv
// Combinational hex nibble to active-high 7-segment decoder.
module decod_hex7
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex7(nibble_i);

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed 7-segment scanner with dead time, per-digit blanking and polarity select.
// Optional blink support is compiled in when DISPLAY_SCAN_BLINK_EN is defined.
module display_scan
  import display_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int PRESCALE   = 50000,
  parameter int DEAD       = 1,
  parameter int ACTIVE_LOW = 0
`ifdef DISPLAY_SCAN_BLINK_EN
  , parameter int BLINK_DIV = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] valor,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   apagar,
`ifdef DISPLAY_SCAN_BLINK_EN
  input  logic [N_DIGITS-1:0]   piscar,
`endif
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic [2:0]            digito
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] DEAD_C   = CNT_W'(DEAD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic             POL      = (ACTIVE_LOW != 0);
  localparam logic [N_DIGITS-1:0] AN_IDLE  = {N_DIGITS{POL}};
  localparam logic [6:0]          SEG_IDLE = SEG_OFF ^ {7{POL}};

  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [2:0]            digito_q;

  logic [N_DIGITS-1:0]   sel_oh;
  logic [3:0]            cur_nib;
  logic [6:0]            seg_raw;
  logic                  slot_end;
  logic                  in_dead;
  logic                  blank;
  logic                  show;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_sel
    assign sel_oh[gi] = (idx_q == IDX_W'(gi));
  end

  always_comb begin
    cur_nib = 4'h0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (sel_oh[i]) cur_nib = shadow_q[4*i +: 4];
    end
  end

  decod_hex7 u_decod (
    .nibble_i (cur_nib),
    .seg_o    (seg_raw)
  );

  assign slot_end = (cnt_q == CNT_LAST);
  assign in_dead  = (cnt_q < DEAD_C);

`ifdef DISPLAY_SCAN_BLINK_EN
  localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_DIV - 1);

  logic [FRM_W-1:0] frame_q;
  logic             phase_q;
  logic             frame_end;

  assign frame_end = slot_end && (idx_q == IDX_LAST);

  // A frame completes when the last digit's slot expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      phase_q <= 1'b0;
    end else if (frame_end) begin
      if (frame_q == FRM_LAST) begin
        frame_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        frame_q <= frame_q + FRM_W'(1);
      end
    end
  end

  assign blank = (|(sel_oh & apagar)) || (phase_q && (|(sel_oh & piscar)));
`else
  assign blank = |(sel_oh & apagar);
`endif

  assign show = !in_dead && !blank;

  always_comb begin
    shadow_d = load ? valor : shadow_q;
    cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    an_d     = show ? sel_oh  : '0;
    seg_d    = show ? seg_raw : SEG_OFF;
  end

  // Outputs are registered after the polarity flip so the pins never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      an_q     <= AN_IDLE;
      seg_q    <= SEG_IDLE;
      digito_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      an_q     <= an_d ^ AN_IDLE;
      seg_q    <= seg_d ^ {7{POL}};
      digito_q <= idx_q;
    end
  end

  assign seg    = seg_q;
  assign an     = an_q;
  assign digito = digito_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan: a 4-digit active-high instance and a 1-digit active-low instance.
module tb_display_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  = 1'b1;
  logic [15:0] valor  = '0;
  logic        load   = 1'b0;
  logic [3:0]  apagar = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [2:0]  digito;

  logic [3:0]  valor2  = '0;
  logic        load2   = 1'b0;
  logic [0:0]  apagar2 = '0;
  logic [6:0]  seg2;
  logic [0:0]  an2;
  logic [2:0]  digito2;

`ifdef DISPLAY_SCAN_BLINK_EN
  logic [3:0]  piscar  = '0;
  logic [0:0]  piscar2 = '0;
`endif

  int tests = 0;
  int fails = 0;

  logic [3:0] an_tab [16] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
                              4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8};
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  display_scan #(
    .N_DIGITS(4), .PRESCALE(4), .DEAD(1), .ACTIVE_LOW(0)
`ifdef DISPLAY_SCAN_BLINK_EN
    , .BLINK_DIV(2)
`endif
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .valor  (valor),
    .load   (load),
    .apagar (apagar),
`ifdef DISPLAY_SCAN_BLINK_EN
    .piscar (piscar),
`endif
    .seg    (seg),
    .an     (an),
    .digito (digito)
  );

  display_scan #(
    .N_DIGITS(1), .PRESCALE(4), .DEAD(1), .ACTIVE_LOW(1)
  ) dut_al (
    .clk    (clk),
    .rst_n  (rst_n),
    .valor  (valor2),
    .load   (load2),
    .apagar (apagar2),
`ifdef DISPLAY_SCAN_BLINK_EN
    .piscar (piscar2),
`endif
    .seg    (seg2),
    .an     (an2),
    .digito (digito2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges, then load on the first edge after release (edge k=1).
  task automatic restart(input logic [15:0] v);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    rst_n  = 1'b1;
    valor  = v;
    load   = 1'b1;
    valor2 = 4'h8;
    load2  = 1'b1;
    tick();
    load  = 1'b0;
    load2 = 1'b0;
  endtask

  task automatic scan_check(input string tag, input logic [15:0] v, input int ncyc);
    int slot;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    for (int k = 1; k <= ncyc; k++) begin
      slot    = ((k - 1) / 4) % 4;
      exp_an  = an_tab[(k - 1) % 16];
      if (apagar[slot]) exp_an = 4'h0;
      exp_seg = (exp_an == 4'h0) ? 7'h00 : hex_tab[v[4*slot +: 4]];
      check($sformatf("%s an k=%0d", tag, k), 32'(an), 32'(exp_an));
      check($sformatf("%s seg k=%0d", tag, k), 32'(seg), 32'(exp_seg));
      check($sformatf("%s digito k=%0d", tag, k), 32'(digito), 32'(slot));
      $display("[TB] %s k=%0d an=%b seg=%h digito=%0d", tag, k, an, seg, digito);
      tick();
    end
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst an", 32'(an), 32'h0);
    check("rst seg", 32'(seg), 32'h0);
    check("rst digito", 32'(digito), 32'h0);
    check("rst an_al", 32'(an2), 32'h1);
    check("rst seg_al", 32'(seg2), 32'h7F);
    $display("[TB] reset an=%b seg=%h an_al=%b seg_al=%h", an, seg, an2, seg2);

    // Plain scan of 3210 over two frames
    apagar = 4'b0000;
    restart(16'h3210);
    scan_check("scan", 16'h3210, 32);

    // Slot 2 masked
    apagar = 4'b0100;
    restart(16'hFFFF);
    scan_check("apagar", 16'hFFFF, 16);
    apagar = 4'b0000;

    // Reset mid slot 2
    restart(16'h3210);
    for (int i = 0; i < 9; i++) tick();
    check("pre-rst an", 32'(an), 32'h4);
    #1 rst_n = 1'b0;
    #1;
    check("mid-rst an", 32'(an), 32'h0);
    check("mid-rst seg", 32'(seg), 32'h0);
    check("mid-rst digito", 32'(digito), 32'h0);
    $display("[TB] mid-reset an=%b seg=%h", an, seg);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post-rst k1 an", 32'(an), 32'h0);
    tick();
    check("post-rst k2 an", 32'(an), 32'h1);
    check("post-rst k2 seg", 32'(seg), 32'h3F);
    $display("[TB] post-reset an=%b seg=%h", an, seg);

    // Load in the middle of slot 0
    restart(16'h3210);
    tick();
    check("load k2 seg", 32'(seg), 32'h3F);
    valor = 16'hABCD;
    load  = 1'b1;
    tick();
    load = 1'b0;
    check("load k3 an", 32'(an), 32'h1);
    check("load k3 seg", 32'(seg), 32'h3F);
    tick();
    check("load k4 an", 32'(an), 32'h1);
    check("load k4 seg", 32'(seg), 32'h5E);
    tick();
    check("load k5 an", 32'(an), 32'h0);
    check("load k5 seg", 32'(seg), 32'h0);
    tick();
    check("load k6 an", 32'(an), 32'h2);
    check("load k6 seg", 32'(seg), 32'h39);
    $display("[TB] load an=%b seg=%h", an, seg);

    // Active-low single-digit instance
    restart(16'h0000);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("al an k=%0d", k), 32'(an2), ((k - 1) % 4 == 0) ? 32'h1 : 32'h0);
      check($sformatf("al seg k=%0d", k), 32'(seg2), ((k - 1) % 4 == 0) ? 32'h7F : 32'h00);
      check($sformatf("al digito k=%0d", k), 32'(digito2), 32'h0);
      $display("[TB] al k=%0d an=%b seg=%h", k, an2, seg2);
      tick();
    end

`ifdef DISPLAY_SCAN_BLINK_EN
    // Blink digit 0 with a 2-frame phase
    piscar = 4'b0001;
    restart(16'h3210);
    begin
      int k;
      k = 1;
      for (int f = 0; f < 6; f++) begin
        while (k < 16 * f + 3) begin
          tick();
          k++;
        end
        check($sformatf("blink an f=%0d", f), 32'(an), (f == 2 || f == 3) ? 32'h0 : 32'h1);
        check($sformatf("blink seg f=%0d", f), 32'(seg), (f == 2 || f == 3) ? 32'h0 : 32'h3F);
        $display("[TB] blink frame=%0d an=%b seg=%h", f, an, seg);
      end
    end
    piscar = 4'b0000;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
